// File: rtl/test_result_uart.sv
// Snoops register-file writebacks for the riscv-tests result registers and reports
// the verdict as an ASCII line on an 8N1 UART. Define TRU_TESTNUM_HEX_EN for hex test numbers.
module test_result_uart #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned SETTLE_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        uart_txd,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`ifdef TRU_TESTNUM_HEX_EN
    localparam logic [3:0] FAIL_LAST = 4'd10;
`else
    localparam logic [3:0] FAIL_LAST = 4'd8;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_LOAD, S_START, S_DATA, S_STOP, S_FIN
    } state_t;

    state_t         state_q;
    logic [31:0]    tnum_q, tnum_d;
    logic [31:0]    pflag_q, pflag_d;
    logic [SW-1:0]  settle_q;
    logic [BW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [3:0]     idx_q;
    logic [7:0]     shift_q;
    logic [7:0]     hi_q, lo_q;
    logic           verdict_q;
    logic           txd_q, busy_q, done_q, pass_q;

    logic           snoop_en;
    logic           done_evt;
    logic [3:0]     last_idx;
    logic [7:0]     snap_hi, snap_lo;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    function automatic logic [7:0] msg_byte(input logic v, input logic [3:0] i,
                                            input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] b;
        b = 8'h00;
        if (v) begin
            case (i)
                4'd0: b = 8'h50;
                4'd1: b = 8'h41;
                4'd2: b = 8'h53;
                4'd3: b = 8'h53;
                4'd4: b = 8'h0D;
                4'd5: b = 8'h0A;
                default: b = 8'h00;
            endcase
        end else begin
            case (i)
                4'd0: b = 8'h46;
                4'd1: b = 8'h41;
                4'd2: b = 8'h49;
                4'd3: b = 8'h4C;
                4'd4: b = 8'h20;
`ifdef TRU_TESTNUM_HEX_EN
                4'd5: b = 8'h30;
                4'd6: b = 8'h78;
                4'd7: b = hi;
                4'd8: b = lo;
                4'd9: b = 8'h0D;
                4'd10: b = 8'h0A;
`else
                4'd5: b = hi;
                4'd6: b = lo;
                4'd7: b = 8'h0D;
                4'd8: b = 8'h0A;
`endif
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Shadow capture; the forwarded value lets a same-cycle write reach the snapshot
    always_comb begin
        snoop_en = (state_q == S_IDLE) || (state_q == S_SETTLE);
        tnum_d   = tnum_q;
        pflag_d  = pflag_q;
        if (snoop_en && wb_en && (wb_addr == 5'd3))
            tnum_d = wb_data;
        if (snoop_en && wb_en && (wb_addr == 5'd27))
            pflag_d = wb_data;
        done_evt = (state_q == S_IDLE) && wb_en && (wb_addr == 5'd26) && (wb_data == 32'd1);
        last_idx = verdict_q ? 4'd5 : FAIL_LAST;
`ifdef TRU_TESTNUM_HEX_EN
        snap_hi = hex_ascii(tnum_d[7:4]);
        snap_lo = hex_ascii(tnum_d[3:0]);
`else
        if (tnum_d > 32'd99) begin
            snap_hi = 8'h3F;
            snap_lo = 8'h3F;
        end else begin
            snap_hi = 8'h30 + 8'(tnum_d[6:0] / 7'd10);
            snap_lo = 8'h30 + 8'(tnum_d[6:0] % 7'd10);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tnum_q    <= '0;
            pflag_q   <= '0;
            settle_q  <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            verdict_q <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            tnum_q  <= tnum_d;
            pflag_q <= pflag_d;
            case (state_q)
                S_IDLE: begin
                    if (done_evt) begin
                        settle_q <= SW'(SETTLE_CYCLES - 1);
                        busy_q   <= 1'b1;
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        verdict_q <= (pflag_d == 32'd1);
                        hi_q      <= snap_hi;
                        lo_q      <= snap_lo;
                        idx_q     <= '0;
                        state_q   <= S_LOAD;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                S_LOAD: begin
                    shift_q <= msg_byte(verdict_q, idx_q, hi_q, lo_q);
                    txd_q   <= 1'b0;
                    baud_q  <= BW'(CLKS_PER_BIT - 1);
                    state_q <= S_START;
                end
                S_START: begin
                    if (baud_q == '0) begin
                        txd_q   <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= '0;
                        baud_q  <= BW'(CLKS_PER_BIT - 1);
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BW'(CLKS_PER_BIT - 1);
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_q == '0) begin
                        if (idx_q == last_idx) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= verdict_q;
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= S_LOAD;
                        end
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                S_FIN: begin
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_test_result_uart.sv
// Self-checking bench for test_result_uart: decodes the UART line and compares against
// verdict strings formatted directly from the reported test number and pass flag.
module tb_test_result_uart;

    localparam int unsigned CPB = 4;
    localparam int unsigned SET = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        uart_txd, busy, done, pass;

    int compared   = 0;
    int mismatched = 0;

    test_result_uart #(.CLKS_PER_BIT(CPB), .SETTLE_CYCLES(SET)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .uart_txd(uart_txd), .busy(busy), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string expected_msg(input logic [31:0] tn, input logic [31:0] pf);
        if (pf == 32'd1) return $sformatf("PASS%c%c", 8'h0D, 8'h0A);
`ifdef TRU_TESTNUM_HEX_EN
        return $sformatf("FAIL 0x%02X%c%c", tn[7:0], 8'h0D, 8'h0A);
`else
        if (tn > 32'd99) return $sformatf("FAIL ??%c%c", 8'h0D, 8'h0A);
        return $sformatf("FAIL %02d%c%c", tn, 8'h0D, 8'h0A);
`endif
    endfunction

    function automatic string hexs(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h", r, s[i]);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(negedge clk);
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic rx_byte(output logic [7:0] b, output int waited, output bit ok);
        ok = 1'b0; waited = 0; b = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            waited++;
            if (uart_txd === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        repeat (CPB / 2) @(posedge clk);
        #1;
        if (uart_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            b[i] = uart_txd;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (uart_txd !== 1'b1) ok = 1'b0;
    endtask

    task automatic rx_msg(output string s, output int first_wait, output bit ok);
        logic [7:0] b;
        int w;
        bit bok;
        s = ""; ok = 1'b1; first_wait = 0;
        for (int n = 0; n < 12; n++) begin
            rx_byte(b, w, bok);
            if (n == 0) first_wait = w;
            if (!bok) begin ok = 1'b0; break; end
            s = $sformatf("%s%c", s, b);
            if (b == 8'h0A) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #1;
        compared++;
        if ({uart_txd, busy, done, pass} !== 4'b1000) begin
            mismatched++;
            $display("FAIL reset_values: txd/busy/done/pass=%b expected 1000", {uart_txd, busy, done, pass});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({uart_txd, busy, done, pass} !== 4'b1000) begin
            mismatched++;
            $display("FAIL reset_idle: txd/busy/done/pass=%b expected 1000", {uart_txd, busy, done, pass});
        end
    endtask

    task automatic test_pass_run();
        string s, exp;
        int fw;
        bit ok;
        do_reset();
        wb_write(5'd27, 32'd1);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL pass_busy_pre: busy=%b expected 0", busy);
        end
        wb_write(5'd26, 32'd1);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL pass_busy_rise: busy=%b expected 1", busy);
        end
        rx_msg(s, fw, ok);
        exp = expected_msg(32'd0, 32'd1);
        compared++;
        if (!ok || s != exp) begin
            mismatched++; $display("FAIL pass_msg: got %s expected %s", hexs(s), hexs(exp));
        end
        compared++;
        if (fw + 1 != int'(SET + 2)) begin
            mismatched++; $display("FAIL pass_first_start: %0d cycles expected %0d", fw + 1, SET + 2);
        end
        repeat (CPB) @(posedge clk);
        #1;
        compared++;
        if ({done, pass, busy, uart_txd} !== 4'b1101) begin
            mismatched++; $display("FAIL pass_final: done/pass/busy/txd=%b expected 1101", {done, pass, busy, uart_txd});
        end
    endtask

    task automatic test_fail_run();
        string s, exp;
        int fw;
        bit ok;
        do_reset();
        wb_write(5'd3, 32'd7);
        wb_write(5'd27, 32'd0);
        wb_write(5'd26, 32'd1);
        rx_msg(s, fw, ok);
        exp = expected_msg(32'd7, 32'd0);
        compared++;
        if (!ok || s != exp) begin
            mismatched++; $display("FAIL fail_msg: got %s expected %s", hexs(s), hexs(exp));
        end
        repeat (CPB) @(posedge clk);
        #1;
        compared++;
        if ({done, pass, busy} !== 3'b100) begin
            mismatched++; $display("FAIL fail_final: done/pass/busy=%b expected 100", {done, pass, busy});
        end
    endtask

    task automatic test_late_pass();
        string s, exp;
        int fw;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            wb_write(5'd26, 32'd1);
            fork
                rx_msg(s, fw, ok);
                begin
                    repeat ((k == 0) ? 3 : 9) @(negedge clk);
                    wb_write(5'd27, 32'd1);
                end
            join
            exp = (k == 0) ? expected_msg(32'd0, 32'd1) : expected_msg(32'd0, 32'd0);
            compared++;
            if (!ok || s != exp) begin
                mismatched++;
                $display("FAIL late_pass_msg[%0d]: got %s expected %s", k, hexs(s), hexs(exp));
            end
            repeat (CPB) @(posedge clk);
            #1;
            compared++;
            if ({done, pass} !== {1'b1, (k == 0)}) begin
                mismatched++;
                $display("FAIL late_pass_verdict[%0d]: done/pass=%b%b expected 1%b", k, done, pass, k == 0);
            end
        end
    endtask

    task automatic test_ignored_traffic();
        string s, exp;
        int fw;
        bit ok, bad;
        do_reset();
        wb_write(5'd26, 32'd2);
        wb_write(5'd26, 32'd0);
        wb_write(5'd0, 32'd1);
        wb_write(5'd0, 32'hFFFF_FFFF);
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || uart_txd !== 1'b1) bad = 1'b1;
        end
        compared++;
        if (bad) begin
            mismatched++; $display("FAIL ignored_idle: busy/txd left idle, busy=%b txd=%b", busy, uart_txd);
        end
        wb_write(5'd3, 32'd123);
        wb_write(5'd27, 32'd0);
        wb_write(5'd26, 32'd1);
        rx_msg(s, fw, ok);
        exp = expected_msg(32'd123, 32'd0);
        compared++;
        if (!ok || s != exp) begin
            mismatched++; $display("FAIL ignored_big_tnum: got %s expected %s", hexs(s), hexs(exp));
        end
    endtask

    task automatic test_reset_mid_byte();
        string s, exp;
        logic [7:0] b;
        int fw, w;
        bit ok, seen;
        do_reset();
        wb_write(5'd27, 32'd1);
        wb_write(5'd26, 32'd1);
        rx_byte(b, w, ok);
        rx_byte(b, w, ok);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (uart_txd === 1'b0) begin seen = 1'b1; break; end
        end
        compared++;
        if (!seen) begin
            mismatched++; $display("FAIL mid_third_start: no start bit for byte 2 seen");
        end
        repeat (CPB * 3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compared++;
        if ({uart_txd, busy} !== 2'b10) begin
            mismatched++; $display("FAIL mid_reset_async: txd/busy=%b expected 10", {uart_txd, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        wb_write(5'd27, 32'd1);
        wb_write(5'd26, 32'd1);
        rx_msg(s, fw, ok);
        exp = expected_msg(32'd0, 32'd1);
        compared++;
        if (!ok || s != exp) begin
            mismatched++; $display("FAIL mid_rerun_msg: got %s expected %s", hexs(s), hexs(exp));
        end
    endtask

    task automatic test_sticky_fin();
        bit seen, bad;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        compared++;
        if (!seen) begin
            mismatched++; $display("FAIL sticky_done: done=%b expected 1", done);
        end
        wb_write(5'd26, 32'd1);
        wb_write(5'd27, 32'd0);
        wb_write(5'd3, 32'd5);
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ({uart_txd, busy, done, pass} !== 4'b1011) bad = 1'b1;
        end
        compared++;
        if (bad) begin
            mismatched++;
            $display("FAIL sticky_fin: txd/busy/done/pass=%b expected 1011", {uart_txd, busy, done, pass});
        end
    endtask

    task automatic test_random_runs();
        string s, exp;
        int fw;
        bit ok;
        logic [31:0] tn, pf;
        for (int n = 0; n < 8; n++) begin
            tn = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 150));
            case ($urandom_range(0, 3))
                0, 3: pf = 32'd1;
                1: pf = 32'd0;
                default: pf = 32'($urandom);
            endcase
            do_reset();
            wb_write(5'd3, 32'($urandom));
            wb_write(5'd27, 32'($urandom));
            wb_write(5'd3, tn);
            wb_write(5'd27, pf);
            wb_write(5'd26, 32'd1);
            rx_msg(s, fw, ok);
            exp = expected_msg(tn, pf);
            compared++;
            if (!ok || s != exp) begin
                mismatched++;
                $display("FAIL random_msg[%0d] tnum=%0d pflag=%0h: got %s expected %s", n, tn, pf, hexs(s), hexs(exp));
            end
            repeat (CPB) @(posedge clk);
            #1;
            compared++;
            if ({done, pass} !== {1'b1, pf == 32'd1}) begin
                mismatched++;
                $display("FAIL random_verdict[%0d]: done/pass=%b%b expected 1%b", n, done, pass, pf == 32'd1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        test_reset();
        test_pass_run();
        test_fail_run();
        test_late_pass();
        test_ignored_traffic();
        test_reset_mid_byte();
        test_sticky_fin();
        test_random_runs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/test_result_uart.md
# test_result_uart

Hardware pass/fail reporter for the RV32I pipeline SoC. It snoops the register-file writeback port and tracks the riscv-tests result registers: x3 holds the test number, x26 is the done flag, and x27 is the pass flag. When x26 is written with 1, it waits a settle window. It then sends a fixed ASCII verdict over an 8N1 UART line, so a board run reports the same verdict the simulation bench prints.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit. Minimum is 2.
- `SETTLE_CYCLES`, default 200: cycles from the x26 done event to the verdict snapshot. Minimum is 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock, same as the CPU core.
- `rst` input 1: asynchronous active-high reset.
- `wb_en` input 1: register-file write enable.
- `wb_addr` input 5: destination register index.
- `wb_data` input 32: write data.
- `uart_txd` output 1: serial out. Idle level is high.
- `busy` output 1: high from the done event until the last stop bit finishes.
- `done` output 1: sticky. High once the message is fully sent.
- `pass` output 1: sticky verdict. Valid while `done` is high.

## Operation
- Shadow registers `tnum` (32 bits) and `pflag` (32 bits) capture every write with `wb_addr` 3 and 27 respectively.
  - A write with `wb_addr` 0 is ignored.
  - Capture continues in IDLE and SETTLE and freezes afterwards.
- States are IDLE → SETTLE → LOAD → START → DATA → STOP → (LOAD | FIN).
- **IDLE:** a write to x26 with `wb_data == 32'd1` moves to SETTLE and loads the counter with `SETTLE_CYCLES-1`. Writes to x26 with any other value are ignored.
- **SETTLE:**
  - The counter decrements each cycle.
  - At 0, the block snapshots `verdict = (pflag == 1)` and selects the message.
  - Further x26 writes are ignored.
- **Message selection:**
  - Pass message: "PASS\r\n", 6 bytes.
  - Fail message: "FAIL dd\r\n", 9 bytes. dd is two ASCII digits of `tnum` in decimal.
  - If `tnum` > 99, both digits are '?' (0x3F).
- **LOAD:** fetches byte[idx] from the message. `idx` starts at 0.
- **START / DATA / STOP:**
  - START drives the start bit (0), then DATA sends 8 data bits LSB first, then STOP drives the stop bit (1).
  - Each bit is held exactly `CLKS_PER_BIT` cycles.
- **After STOP:** if `idx` is the last index, go to FIN; otherwise `idx++` and go to LOAD.
- **FIN:** terminal state.
  - `done` = 1, `pass` = verdict, `busy` = 0, `uart_txd` = 1.
  - The block stays in FIN until `rst`, and ignores all snoop traffic.
- If a write to x27 and the x26 done event happen in the same cycle, the x27 value is captured, since it lands before the SETTLE snapshot.

## Timing
- **Reset values:**
  - `uart_txd` = 1, `busy` = 0, `done` = 0, `pass` = 0.
  - State is IDLE; `tnum`, `pflag`, `idx` and the counters are 0.
- **Reset mid-transmission:** `uart_txd` returns high immediately (asynchronously). No partial byte is resumed.
- **`busy`:** rises in the cycle after the qualifying x26 write is sampled.
- **First start bit:** `uart_txd` goes low in cycle SETTLE_CYCLES+2 after the qualifying write edge (SETTLE plus one LOAD cycle).
- **Per byte:**
  - Each byte costs 1 LOAD cycle plus 10×`CLKS_PER_BIT` cycles.
  - The line stays high during the LOAD cycle, so there is no inter-byte gap other than that one cycle.
- **Register outputs:**
  - `uart_txd` is driven from a flop, so there is no combinational path from the `wb_*` inputs.
  - `done` and `pass` assert in the same cycle the last stop bit ends.

## Configuration
- Macro `TRU_TESTNUM_HEX_EN` is compiled in or out at build time.
- **Defined:**
  - The fail message is "FAIL 0xhh\r\n", 11 bytes.
  - hh is `tnum[7:0]` as two uppercase hex digits.
  - No '?' substitution is applied.
- **Undefined:** decimal formatting as described in Operation.
- The pass message and all timing rules are identical in both builds.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `SETTLE_CYCLES`=10. The bench decodes `uart_txd`.

1. **Pass run:** write x27=1, then x26=1.
   - Decoded bytes are 50 41 53 53 0D 0A.
   - `done` = 1, `pass` = 1.
   - The first start bit lands exactly 12 cycles after the x26 write.
2. **Fail run:** write x3=7, x27=0, then x26=1.
   - Decoded text is "FAIL 07\r\n".
   - `pass` = 0, `done` = 1.
3. **Late pass flag:** write x26=1, then x27=1 five cycles later.
   - The verdict is PASS, because the write falls inside the settle window.
   - The same x27 write 11 cycles later (outside the window) gives FAIL.
4. **Ignored traffic:**
   - x26=2, x26=0 and any `wb_addr`=0 write never leave IDLE; `busy` stays 0 for 500 cycles.
   - x3=123 followed by a fail run decodes "FAIL ??\r\n", or "FAIL 0x7B\r\n" with `TRU_TESTNUM_HEX_EN`.
5. **Reset mid-byte:** assert `rst` during DATA of byte 2.
   - `uart_txd` is 1 and `busy` is 0 immediately.
   - A new pass run after release decodes the full "PASS\r\n".
6. **Sticky FIN:** after `done`, issue another x26=1 and x27 write.
   - No further UART activity occurs.
   - `done` and `pass` are unchanged.
